// File: rtl/uart_rx.sv
// uart_rx: 8-bit, LSB-first, single-stop-bit UART receiver.
// The asynchronous rx line goes through a two-flop synchronizer. The start
// bit is confirmed at mid-bit and every later bit is sampled at its centre.
// Each good byte is reported with a one-cycle valid strobe. A low stop bit
// produces a one-cycle frame_err strobe, and the receiver then waits for the
// line to return high.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit, and drives parity_err.
// Handshake: there is no backpressure. valid is high for exactly one cycle,
// and data_out holds that byte until the next good frame. The consumer must
// capture data_out on or after valid and before the next valid.
// CLK_FREQ / BAUD_RATE must be at least 2.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       ck_rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int          CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  // Synchronizer stages. Both stages idle high, like the line.
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_s;

  // Receiver state.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic             half_done;
  logic             full_done;

  assign rx_s      = sync2_q;
  assign half_done = (baud_cnt_q == HALF_LAST);
  assign full_done = (baud_cnt_q == FULL_LAST);

  // Synchronizer next-state: shift the raw line through two stages.
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
  end

  // Receive FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = 3'd0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Confirm the start bit half a bit later. A line that is high again
      // by then was a glitch.
      S_START: begin
        if (half_done) begin
          baud_cnt_d = '0;
          state_d    = rx_s ? S_IDLE : S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end

      // Shift in LSB first: each new bit enters at the MSB.
      S_DATA: begin
        if (full_done) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_done) begin
          baud_cnt_d = '0;
          par_bit_d  = rx_s;
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end
`endif

      // Return to IDLE at the stop-bit centre, so a frame that follows
      // with no idle time is still caught.
      S_STOP: begin
        if (full_done) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ^{shift_q, par_bit_q};
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end

      // A line held low (break) must not be read as a stream of frames.
      S_BREAK: begin
        baud_cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
        bit_cnt_d  = 3'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Register bank with asynchronous active-low reset.
  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // The two strobes come from exclusive branches of the STOP state.
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!ck_rst)
    !(valid_q && frame_err_q));

  // busy is a registered copy of "state is not IDLE".
  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!ck_rst)
    busy_q == (state_q != S_IDLE));

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a scoreboard of expected
// receive events. The clock-to-baud ratio is shortened so that the run stays
// small; 100 MHz / 990 kbaud truncates to 101 clocks per bit, 50 per half bit.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 990_000;
  localparam int          C         = int'(CLK_FREQ / BAUD_RATE);
  localparam int          H         = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN  = 1'b1;
  localparam int LAT_LIT = 1063;  // 3 + 50 + 10*101
`else
  localparam bit PAR_EN  = 1'b0;
  localparam int LAT_LIT = 962;   // 3 + 50 + 9*101
`endif

  logic       clk;
  logic       ck_rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .ck_rst    (ck_rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Scoreboard entry: [9] frame error expected, [8] parity_err, [7:0] byte.
  logic [9:0] exp_q[$];
  int         valid_cyc_q[$];
  int         busy_rise_q[$];
  int         checks      = 0;
  int         failures    = 0;
  int         cyc         = 0;
  int         valid_total = 0;
  int         ferr_total  = 0;
  int         busy_cycles = 0;
  logic [7:0] model_data  = 8'h00;
  logic       busy_prev   = 1'b0;
  logic [9:0] cmp_e;
  logic [7:0] pats [4]    = '{8'h01, 8'h80, 8'hC3, 8'h6E};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected parity_err for a frame: even parity over data plus parity bit.
  function automatic logic perr_of(input logic [7:0] b, input logic p);
    return PAR_EN ? ((^b) ^ p) : 1'b0;
  endfunction

  function automatic logic [9:0] ev_valid(input logic [7:0] b, input logic p);
    return {1'b0, perr_of(b, p), b};
  endfunction

  localparam logic [9:0] EV_FERR = 10'h200;

  // ---------------- driver tasks ----------------
  // Transmit one frame; each bit lasts `period` clocks, driven at negedges.
  task automatic send_frame(input logic [7:0] b, input int period,
                            input logic stop_v, input logic par_v);
    rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (period) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_v;
      repeat (period) @(negedge clk);
    end
    rx = stop_v;
    repeat (period) @(negedge clk);
  endtask

  // Well-formed frame with correct even parity, expectation queued first.
  task automatic xmit(input logic [7:0] b, input int period);
    exp_q.push_back(ev_valid(b, ^b));
    send_frame(b, period, 1'b1, ^b);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!ck_rst) begin
      check("reset_data_out", int'(data_out), 0);
      check("reset_strobes_busy", int'({valid, frame_err, parity_err, busy}), 0);
      model_data = 8'h00;
      busy_prev  = 1'b0;
    end else begin
      check("valid_ferr_exclusive", int'(valid & frame_err), 0);
      if (busy) busy_cycles++;
      if (busy && !busy_prev) busy_rise_q.push_back(cyc);
      if (valid || frame_err) begin
        if (valid) begin
          valid_total++;
          valid_cyc_q.push_back(cyc);
          check("busy_low_at_valid", int'(busy), 0);
          check("busy_high_before_valid", int'(busy_prev), 1);
        end
        if (frame_err) ferr_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'({valid, frame_err}), 0);
        end else begin
          cmp_e = exp_q.pop_front();
          check("event_is_frame_err", int'(frame_err), int'(cmp_e[9]));
          check("parity_err", int'(parity_err), int'(cmp_e[8] & ~cmp_e[9]));
          if (!cmp_e[9]) begin
            check("data_out_new", int'(data_out), int'(cmp_e[7:0]));
            model_data = cmp_e[7:0];
          end else begin
            check("data_out_held_on_ferr", int'(data_out), int'(model_data));
          end
        end
      end else begin
        check("data_out_held", int'(data_out), int'(model_data));
        check("parity_err_without_valid", int'(parity_err), 0);
      end
      busy_prev = busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int vi;
    int bi;
    int lat;
    int rel;
    int n0;
    int f0;
    int b0;

    ck_rst = 1'b0;
    rx     = 1'b1;
    repeat (5) @(negedge clk);
    #3 ck_rst = 1'b1;
    @(negedge clk);
    check("idle_busy_after_reset", int'(busy), 0);
    check("idle_data_after_reset", int'(data_out), 0);
    idle(C);

    // Loopback: three frames back-to-back, no idle time between them.
    vi = valid_cyc_q.size();
    bi = busy_rise_q.size();
    n0 = valid_total;
    f0 = ferr_total;
    s  = cyc;
    xmit(8'hA5, C);
    xmit(8'h00, C);
    xmit(8'hFF, C);
    idle(C);
    lat = (valid_cyc_q.size() > vi) ? valid_cyc_q[vi] - s : -1;
    check_range("first_valid_latency", lat, LAT_LIT - 1, LAT_LIT + 1);
    rel = (busy_rise_q.size() > bi) ? busy_rise_q[bi] - s : -1;
    check("busy_rise_cycle", rel, 3);
    check("loopback_valid_count", valid_total - n0, 3);
    check("loopback_frame_err_count", ferr_total - f0, 0);
    check("loopback_drained", exp_q.size(), 0);
    check("loopback_last_byte", int'(data_out), 8'hFF);

    // Further byte patterns with an idle gap.
    for (int i = 0; i < 4; i++) begin
      xmit(pats[i], C);
      idle(C / 3 + i * 7);
    end
    check("patterns_drained", exp_q.size(), 0);
    check("patterns_last_byte", int'(data_out), 8'h6E);

    // Glitch shorter than half a bit: busy pulses, nothing is reported.
    n0 = valid_total;
    f0 = ferr_total;
    b0 = busy_cycles;
    rx = 1'b0;
    repeat (H - 20) @(negedge clk);
    idle(2 * C);
    check("glitch_busy_seen", int'(busy_cycles > b0), 1);
    check("glitch_back_to_idle", int'(busy), 0);
    check("glitch_no_events", (valid_total - n0) + (ferr_total - f0), 0);
    check("glitch_data_unchanged", int'(data_out), 8'h6E);

    // Framing error, then a held-low break, then a good frame.
    n0 = valid_total;
    f0 = ferr_total;
    exp_q.push_back(EV_FERR);
    send_frame(8'h3C, C, 1'b0, ^(8'h3C));
    repeat (3 * C) @(negedge clk);
    check("break_still_busy", int'(busy), 1);
    idle(C);
    xmit(8'h5A, C);
    idle(C);
    check("ferr_count", ferr_total - f0, 1);
    check("ferr_then_valid_count", valid_total - n0, 1);
    check("ferr_drained", exp_q.size(), 0);
    check("after_ferr_byte", int'(data_out), 8'h5A);

    // Baud tolerance: transmitter 3 percent slow and 3 percent fast.
    f0 = ferr_total;
    xmit(8'h55, C + 3);
    idle(C);
    xmit(8'h55, C - 3);
    idle(C);
    check("tolerance_no_ferr", ferr_total - f0, 0);
    check("tolerance_drained", exp_q.size(), 0);

    // Reset during data bit 4 of 0x96; the partial byte must vanish.
    n0 = valid_total;
    f0 = ferr_total;
    fork
      send_frame(8'h96, C, 1'b1, ^(8'h96));
      begin
        repeat (5 * C + H) @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        #3 ck_rst = 1'b0;
        #1;
        check("midreset_data_out", int'(data_out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_strobes", int'({valid, frame_err, parity_err}), 0);
      end
    join
    repeat (5) @(negedge clk);
    #3 ck_rst = 1'b1;
    @(negedge clk);
    idle(C);
    check("midreset_no_event", (valid_total - n0) + (ferr_total - f0), 0);
    xmit(8'h42, C);
    idle(C);
    check("after_reset_valid_count", valid_total - n0, 1);
    check("after_reset_byte", int'(data_out), 8'h42);
    check("after_reset_drained", exp_q.size(), 0);

    // Parity: correct bit first, then a wrong one; both bytes delivered.
    if (PAR_EN) begin
      n0 = valid_total;
      exp_q.push_back({1'b0, 1'b0, 8'h07});
      send_frame(8'h07, C, 1'b1, 1'b1);
      idle(C);
      exp_q.push_back({1'b0, 1'b1, 8'h07});
      send_frame(8'h07, C, 1'b1, 1'b0);
      idle(C);
      check("parity_valid_count", valid_total - n0, 2);
      check("parity_drained", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
